// File: rtl/reg_writeback_buffer.sv
// In-order write queue in front of the register file: buffers write requests,
// drains one per cycle onto the write port, and forwards queued values to decode.
module reg_writeback_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_dest,
    input  logic [DW-1:0]              in_data,
    input  logic                       wr_hold,
    output logic                       wr_en,
    output logic [AW-1:0]              wr_dest,
    output logic [DW-1:0]              wr_val,
    input  logic [AW-1:0]              q_src1,
    input  logic [AW-1:0]              q_src2,
    output logic                       hit1,
    output logic                       hit2,
    output logic [DW-1:0]              fwd1,
    output logic [DW-1:0]              fwd2,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] dest_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    // Scan oldest to youngest so the last match (closest to tail) wins.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] addr);
        logic [DW:0]   r;
        logic [PW-1:0] idx;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < cnt) && (addr != '0) && (dest_q[idx] == addr)) begin
                r = {1'b1, data_q[idx]};
            end
        end
        return r;
    endfunction

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    assign in_ready = !full;
    assign wr_en    = !empty && !wr_hold && !flush;
    assign wr_dest  = empty ? '0 : dest_q[head];
    assign wr_val   = empty ? '0 : data_q[head];

    // Writes to r0 complete the handshake but are never stored.
    assign push = in_valid && in_ready && (in_dest != '0) && !flush;
    assign pop  = wr_en;

    always_comb begin
        {hit1, fwd1} = lookup(q_src1);
        {hit2, fwd2} = lookup(q_src2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                dest_q[tail] <= in_dest;
                data_q[tail] <= in_data;
                tail         <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_reg_writeback_buffer.sv
// Directed bench for reg_writeback_buffer: queueing, draining, forwarding,
// r0 filtering, flush and asynchronous reset.
module tb_reg_writeback_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_dest = '0;
    logic [31:0] in_data = '0;
    logic        wr_hold = 1'b0;
    logic        wr_en;
    logic [4:0]  wr_dest;
    logic [31:0] wr_val;
    logic [4:0]  q_src1 = '0;
    logic [4:0]  q_src2 = '0;
    logic        hit1, hit2;
    logic [31:0] fwd1, fwd2;
    logic [2:0]  count;
    logic        empty, full;

    int passed = 0;
    int total  = 0;

    reg_writeback_buffer #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_data(in_data),
        .wr_hold(wr_hold), .wr_en(wr_en), .wr_dest(wr_dest), .wr_val(wr_val),
        .q_src1(q_src1), .q_src2(q_src2), .hit1(hit1), .hit2(hit2),
        .fwd1(fwd1), .fwd2(fwd2), .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [4:0] d, input logic [31:0] v);
        in_valid = 1'b1;
        in_dest  = d;
        in_data  = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({wr_en, in_ready, empty, full, hit1, hit2} !== 6'b011000) $display("FAIL reset_flags got %b want 011000", {wr_en, in_ready, empty, full, hit1, hit2});
        else passed++;
        total++;
        if ({count, wr_dest, wr_val, fwd1, fwd2} !== '0) $display("FAIL reset_values count=%0d dest=%0d val=%h fwd1=%h fwd2=%h want all 0", count, wr_dest, wr_val, fwd1, fwd2);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        step();
        push_one(5'd5, 32'hDEADBEEF);
        total++;
        if ({wr_en, wr_dest, wr_val} !== {1'b1, 5'd5, 32'hDEADBEEF}) $display("FAIL single_drain got en=%b dest=%0d val=%h want 1/5/deadbeef", wr_en, wr_dest, wr_val);
        else passed++;
        step();
        total++;
        if (empty !== 1'b1 || count !== 3'd0) $display("FAIL single_empty got empty=%b count=%0d want 1/0", empty, count);
        else passed++;
    endtask

    task automatic test_full_hold();
        wr_hold = 1'b1;
        for (int k = 0; k < 4; k++) push_one(5'(k + 1), 32'h11 * (k + 1));
        in_valid = 1'b1;
        in_dest  = 5'd9;
        in_data  = 32'h55;
        #1;
        total++;
        if ({full, in_ready, count} !== {1'b1, 1'b0, 3'd4}) $display("FAIL hold_full got full=%b ready=%b count=%0d want 1/0/4", full, in_ready, count);
        else passed++;
        total++;
        if ({wr_en, wr_dest, wr_val} !== {1'b0, 5'd1, 32'h11}) $display("FAIL hold_stable got en=%b dest=%0d val=%h want 0/1/11", wr_en, wr_dest, wr_val);
        else passed++;
        step();
        in_valid = 1'b0;
        total++;
        if (count !== 3'd4 || wr_dest !== 5'd1) $display("FAIL hold_fifth got count=%0d dest=%0d want 4/1", count, wr_dest);
        else passed++;
        wr_hold = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({wr_en, wr_dest, wr_val} !== {1'b1, 5'(k + 1), 32'h11 * (k + 1)}) $display("FAIL hold_release_%0d got en=%b dest=%0d val=%h want 1/%0d/%h", k, wr_en, wr_dest, wr_val, k + 1, 32'h11 * (k + 1));
            else passed++;
            step();
        end
        total++;
        if (empty !== 1'b1 || wr_en !== 1'b0) $display("FAIL hold_drained got empty=%b en=%b want 1/0", empty, wr_en);
        else passed++;
    endtask

    task automatic test_forward();
        wr_hold = 1'b1;
        push_one(5'd7, 32'hA);
        push_one(5'd7, 32'hB);
        push_one(5'd3, 32'hC);
        q_src1 = 5'd7;
        q_src2 = 5'd0;
        #1;
        total++;
        if ({hit1, fwd1} !== {1'b1, 32'hB}) $display("FAIL fwd_youngest got hit=%b fwd=%h want 1/b", hit1, fwd1);
        else passed++;
        total++;
        if ({hit2, fwd2} !== {1'b0, 32'h0}) $display("FAIL fwd_r0 got hit=%b fwd=%h want 0/0", hit2, fwd2);
        else passed++;
        q_src1 = 5'd9;
        q_src2 = 5'd3;
        #1;
        total++;
        if ({hit1, fwd1, hit2, fwd2} !== {1'b0, 32'h0, 1'b1, 32'hC}) $display("FAIL fwd_miss_tail got h1=%b f1=%h h2=%b f2=%h want 0/0/1/c", hit1, fwd1, hit2, fwd2);
        else passed++;
    endtask

    task automatic test_flush();
        wr_hold  = 1'b0;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_dest  = 5'd6;
        in_data  = 32'h66;
        q_src1   = 5'd6;
        #1;
        total++;
        if ({wr_en, in_ready, count} !== {1'b0, 1'b1, 3'd3}) $display("FAIL flush_cycle got en=%b ready=%b count=%0d want 0/1/3", wr_en, in_ready, count);
        else passed++;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        total++;
        if ({count, empty, hit1, wr_en} !== {3'd0, 1'b1, 1'b0, 1'b0}) $display("FAIL flush_after got count=%0d empty=%b hit=%b en=%b want 0/1/0/0", count, empty, hit1, wr_en);
        else passed++;
    endtask

    task automatic test_dest_zero();
        in_valid = 1'b1;
        in_dest  = 5'd0;
        in_data  = 32'h99;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL r0_ready got %b want 1", in_ready);
        else passed++;
        step();
        in_valid = 1'b0;
        #1;
        total++;
        if ({count, empty, wr_en} !== {3'd0, 1'b1, 1'b0}) $display("FAIL r0_dropped got count=%0d empty=%b en=%b want 0/1/0", count, empty, wr_en);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_d [3];
        exp_d[0] = 5'd3; exp_d[1] = 5'd4; exp_d[2] = 5'd8;
        wr_hold = 1'b1;
        for (int k = 0; k < 4; k++) push_one(5'(k + 1), 32'h100 + k);
        wr_hold  = 1'b0;
        in_valid = 1'b1;
        in_dest  = 5'd8;
        in_data  = 32'h88;
        #1;
        total++;
        if ({in_ready, wr_en, wr_dest} !== {1'b0, 1'b1, 5'd1}) $display("FAIL b2b_full got ready=%b en=%b dest=%0d want 0/1/1", in_ready, wr_en, wr_dest);
        else passed++;
        step();
        total++;
        if ({count, in_ready, wr_dest} !== {3'd3, 1'b1, 5'd2}) $display("FAIL b2b_drain got count=%0d ready=%b dest=%0d want 3/1/2", count, in_ready, wr_dest);
        else passed++;
        step();
        in_valid = 1'b0;
        q_src1   = 5'd8;
        #1;
        total++;
        if ({count, hit1, fwd1} !== {3'd3, 1'b1, 32'h88}) $display("FAIL b2b_accept got count=%0d hit=%b fwd=%h want 3/1/88", count, hit1, fwd1);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({wr_en, wr_dest} !== {1'b1, exp_d[k]}) $display("FAIL b2b_wrap_%0d got en=%b dest=%0d want 1/%0d", k, wr_en, wr_dest, exp_d[k]);
            else passed++;
            step();
        end
        total++;
        if (empty !== 1'b1) $display("FAIL b2b_empty got %b want 1", empty);
        else passed++;
    endtask

    task automatic test_reset_mid();
        wr_hold = 1'b1;
        push_one(5'd10, 32'hA0);
        push_one(5'd11, 32'hB0);
        wr_hold = 1'b0;
        q_src1  = 5'd10;
        #1;
        total++;
        if ({wr_en, wr_dest, hit1} !== {1'b1, 5'd10, 1'b1}) $display("FAIL mid_pre got en=%b dest=%0d hit=%b want 1/10/1", wr_en, wr_dest, hit1);
        else passed++;
        #1;
        rst = 1'b0;
        #1;
        total++;
        if ({wr_en, in_ready, empty, full, hit1, count, wr_dest, wr_val, fwd1} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0}) $display("FAIL mid_reset got en=%b ready=%b empty=%b full=%b hit=%b count=%0d dest=%0d val=%h want 0/1/1/0/0/0/0/0", wr_en, in_ready, empty, full, hit1, count, wr_dest, wr_val);
        else passed++;
        #1;
        rst = 1'b1;
        step();
        total++;
        if ({empty, wr_en} !== {1'b1, 1'b0}) $display("FAIL mid_after got empty=%b en=%b want 1/0", empty, wr_en);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_hold();
        test_forward();
        test_flush();
        test_dest_zero();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
